// File: rtl/hazard_ctrl_pkg.sv
// Shared core definitions for the hazard controller: sequencer states,
// fixed stall lengths and divider op constants.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEM_WAIT  = 2'd1,
        CTRL_WAIT = 2'd2,
        DIV_WAIT  = 2'd3
    } hz_state_t;

    localparam logic [1:0] CTRL_STALL_CYCLES = 2'd3;
    localparam logic [1:0] MEM_STALL_CYCLES  = 2'd1;

    localparam logic [1:0] DIV_NOP  = 2'd0;
    localparam logic [1:0] DIV_DIV  = 2'd1;
    localparam logic [1:0] DIV_REM  = 2'd2;

    // Fixed service order: memory wait first, then control, then divider.
    function automatic hz_state_t pick_wait(input logic mem_busy,
                                            input logic ctrl_busy,
                                            input logic div_busy);
        if (mem_busy)       return MEM_WAIT;
        else if (ctrl_busy) return CTRL_WAIT;
        else if (div_busy)  return DIV_WAIT;
        else                return IDLE;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-destination scoreboard: marks registers with an outstanding
// load/div result and flags decode operands that read them.
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       set_en,
    input  logic [4:0] set_rd,
    input  logic       wb_we,
    input  logic [4:0] wb_rd,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    input  logic       dec_use_rs1,
    input  logic       dec_use_rs2,
    output logic       raw_stall
);

    logic [31:0] pending;
    logic [31:0] pending_next;

    // Clear applied before set so a same-cycle set/clear of one bit leaves it set.
    always_comb begin
        pending_next = pending;
        if (wb_we)
            pending_next[wb_rd] = 1'b0;
        if (set_en && (set_rd != 5'd0))
            pending_next[set_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            pending <= '0;
        else
            pending <= pending_next;
    end

    assign raw_stall = (dec_use_rs1 & pending[dec_rs1]) |
                       (dec_use_rs2 & pending[dec_rs2]);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: inline stall sequencer for load/control/div latency
// plus a pending-register scoreboard for operand (RAW) hazards.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       issue_valid,
    input  logic       issue_ctrl,
    input  logic       issue_load,
    input  logic       issue_div,
    input  logic [4:0] issue_rd,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    input  logic       dec_use_rs1,
    input  logic       dec_use_rs2,
    input  logic       div_ready,
    input  logic       wb_we,
    input  logic [4:0] wb_rd,
    output logic       seq_stall,
    output logic       raw_stall,
    output logic       stall,
    output logic [1:0] hz_state
);

    hz_state_t  state;
    logic [1:0] mem_cnt;
    logic [1:0] ctrl_cnt;
    logic       div_pend;
    logic       accept;

    // Handshake: issue_valid acts as valid, !stall as ready; an instruction
    // transfers only in a run cycle where both hold.
    assign accept    = run & issue_valid & ~stall;
    assign seq_stall = (state != IDLE);
    assign stall     = seq_stall | raw_stall;
    assign hz_state  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mem_cnt  <= '0;
            ctrl_cnt <= '0;
            div_pend <= 1'b0;
        end else if (run) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_cnt  <= issue_load ? MEM_STALL_CYCLES : 2'd0;
                        ctrl_cnt <= issue_ctrl ? CTRL_STALL_CYCLES : 2'd0;
                        div_pend <= issue_div;
                        state    <= pick_wait(issue_load, issue_ctrl, issue_div);
                    end
                end
                MEM_WAIT: begin
                    mem_cnt <= mem_cnt - 2'd1;
                    if (mem_cnt == 2'd1)
                        state <= pick_wait(1'b0, ctrl_cnt != 2'd0, div_pend);
                end
                CTRL_WAIT: begin
                    ctrl_cnt <= ctrl_cnt - 2'd1;
                    if (ctrl_cnt == 2'd1)
                        state <= pick_wait(1'b0, 1'b0, div_pend);
                end
                DIV_WAIT: begin
                    if (div_ready) begin
                        div_pend <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    hazard_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .set_en      (accept & (issue_load | issue_div)),
        .set_rd      (issue_rd),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_use_rs1 (dec_use_rs1),
        .dec_use_rs2 (dec_use_rs2),
        .raw_stall   (raw_stall)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: driver pushes per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset, run, issue_valid, issue_ctrl, issue_load, issue_div;
    logic [4:0] issue_rd, dec_rs1, dec_rs2, wb_rd;
    logic       dec_use_rs1, dec_use_rs2, div_ready, wb_we;
    logic       seq_stall, raw_stall, stall;
    logic [1:0] hz_state;

    logic [4:0] exp_q[$];
    string      name_q[$];
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .run(run), .issue_valid(issue_valid),
        .issue_ctrl(issue_ctrl), .issue_load(issue_load), .issue_div(issue_div),
        .issue_rd(issue_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .div_ready(div_ready), .wb_we(wb_we), .wb_rd(wb_rd),
        .seq_stall(seq_stall), .raw_stall(raw_stall), .stall(stall),
        .hz_state(hz_state)
    );

    task automatic clr();
        reset = 1'b0; run = 1'b1; issue_valid = 1'b0; issue_ctrl = 1'b0;
        issue_load = 1'b0; issue_div = 1'b0; issue_rd = 5'd0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
        div_ready = 1'b0; wb_we = 1'b0; wb_rd = 5'd0;
    endtask

    // Expected outputs for the cycle whose inputs were just driven.
    task automatic cyc(input string nm, input logic [1:0] st, input logic ss, input logic rs);
        exp_q.push_back({st, ss, rs, ss | rs});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [4:0] e;
        logic [4:0] a;
        string      n;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {hz_state, seq_stall, raw_stall, stall};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL %s: got state=%0d seq=%b raw=%b stall=%b, expected state=%0d seq=%b raw=%b stall=%b",
                         n, a[4:3], a[2], a[1], a[0], e[4:3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset", 2'd0, 1'b0, 1'b0);

        // Load rd=5 followed by a dependent read of x5.
        clr(); issue_valid = 1; issue_load = 1; issue_rd = 5'd5;
        cyc("ld_issue", 2'd0, 1'b0, 1'b0);
        clr(); dec_rs1 = 5'd5; dec_use_rs1 = 1;
        cyc("ld_mem_wait", 2'd1, 1'b1, 1'b1);
        clr(); dec_rs1 = 5'd5; dec_use_rs1 = 1; issue_valid = 1; issue_ctrl = 1;
        cyc("ld_raw_blocks_issue", 2'd0, 1'b0, 1'b1);
        clr(); dec_rs1 = 5'd5; dec_use_rs1 = 1;
        cyc("ld_raw_hold", 2'd0, 1'b0, 1'b1);
        clr(); dec_rs1 = 5'd5; dec_use_rs1 = 1; wb_we = 1; wb_rd = 5'd5;
        cyc("ld_wb_cycle", 2'd0, 1'b0, 1'b1);
        clr(); dec_rs1 = 5'd5; dec_use_rs1 = 1;
        cyc("ld_after_wb", 2'd0, 1'b0, 1'b0);

        // jal: three CTRL_WAIT cycles; issue during the stall is refused.
        clr(); issue_valid = 1; issue_ctrl = 1; issue_rd = 5'd1;
        cyc("jal_issue", 2'd0, 1'b0, 1'b0);
        clr();
        cyc("jal_w1", 2'd2, 1'b1, 1'b0);
        clr(); issue_valid = 1; issue_load = 1; issue_rd = 5'd3;
        cyc("jal_w2_refused_issue", 2'd2, 1'b1, 1'b0);
        clr();
        cyc("jal_w3", 2'd2, 1'b1, 1'b0);
        clr(); dec_rs1 = 5'd3; dec_use_rs1 = 1; dec_rs2 = 5'd1; dec_use_rs2 = 1;
        cyc("jal_done", 2'd0, 1'b0, 1'b0);

        // load+ctrl: one MEM_WAIT then three CTRL_WAIT.
        clr(); issue_valid = 1; issue_load = 1; issue_ctrl = 1;
        cyc("lc_issue", 2'd0, 1'b0, 1'b0);
        clr(); cyc("lc_mem", 2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            clr(); cyc("lc_ctrl", 2'd2, 1'b1, 1'b0);
        end
        clr(); cyc("lc_done", 2'd0, 1'b0, 1'b0);

        // run low freezes the ctrl countdown.
        clr(); issue_valid = 1; issue_ctrl = 1;
        cyc("run_issue", 2'd0, 1'b0, 1'b0);
        clr(); cyc("run_w1", 2'd2, 1'b1, 1'b0);
        clr(); run = 0; cyc("run_hold1", 2'd2, 1'b1, 1'b0);
        clr(); run = 0; cyc("run_hold2", 2'd2, 1'b1, 1'b0);
        clr(); cyc("run_w2", 2'd2, 1'b1, 1'b0);
        clr(); cyc("run_w3", 2'd2, 1'b1, 1'b0);
        clr(); cyc("run_done", 2'd0, 1'b0, 1'b0);

        // Write-back clears while run=0; issue with run=0 is ignored.
        clr(); issue_valid = 1; issue_load = 1; issue_rd = 5'd11;
        cyc("wbrun_issue", 2'd0, 1'b0, 1'b0);
        clr(); dec_rs1 = 5'd11; dec_use_rs1 = 1;
        cyc("wbrun_mem", 2'd1, 1'b1, 1'b1);
        clr(); run = 0; wb_we = 1; wb_rd = 5'd11; issue_valid = 1; issue_load = 1; issue_rd = 5'd4;
        cyc("wbrun_stopped", 2'd0, 1'b0, 1'b0);
        clr(); dec_rs1 = 5'd11; dec_use_rs1 = 1; dec_rs2 = 5'd4; dec_use_rs2 = 1;
        cyc("wbrun_cleared", 2'd0, 1'b0, 1'b0);

        // rd=0 is never tracked.
        clr(); issue_valid = 1; issue_load = 1; issue_rd = 5'd0;
        cyc("x0_issue", 2'd0, 1'b0, 1'b0);
        clr(); dec_use_rs1 = 1;
        cyc("x0_mem", 2'd1, 1'b1, 1'b0);
        clr(); dec_use_rs1 = 1;
        cyc("x0_idle", 2'd0, 1'b0, 1'b0);

        // Same-cycle set and clear of x9 leaves it pending.
        clr(); issue_valid = 1; issue_load = 1; issue_rd = 5'd9; wb_we = 1; wb_rd = 5'd9;
        cyc("sc_issue", 2'd0, 1'b0, 1'b0);
        clr(); dec_rs1 = 5'd9; dec_use_rs1 = 1;
        cyc("sc_mem", 2'd1, 1'b1, 1'b1);
        clr(); dec_rs1 = 5'd9; dec_use_rs1 = 1;
        cyc("sc_pending", 2'd0, 1'b0, 1'b1);
        clr(); dec_rs1 = 5'd9; dec_use_rs1 = 1; wb_we = 1; wb_rd = 5'd9;
        cyc("sc_wb", 2'd0, 1'b0, 1'b1);
        clr(); dec_rs1 = 5'd9; dec_use_rs1 = 1;
        cyc("sc_done", 2'd0, 1'b0, 1'b0);

        // div rd=7, div_ready 10 cycles later; div_ready in IDLE is ignored.
        clr(); issue_valid = 1; issue_div = 1; issue_rd = 5'd7; div_ready = 1;
        cyc("div_issue", 2'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            clr(); dec_rs2 = 5'd7; dec_use_rs2 = 1; div_ready = (i == 10);
            cyc("div_wait", 2'd3, 1'b1, 1'b1);
        end
        clr(); dec_rs2 = 5'd7; dec_use_rs2 = 1;
        cyc("div_done_pending", 2'd0, 1'b0, 1'b1);
        clr(); dec_rs2 = 5'd7; dec_use_rs2 = 1; wb_we = 1; wb_rd = 5'd7;
        cyc("div_wb", 2'd0, 1'b0, 1'b1);
        clr(); dec_rs2 = 5'd7; dec_use_rs2 = 1;
        cyc("div_cleared", 2'd0, 1'b0, 1'b0);

        // Reset mid CTRL_WAIT.
        clr(); issue_valid = 1; issue_ctrl = 1;
        cyc("rc_issue", 2'd0, 1'b0, 1'b0);
        clr(); cyc("rc_w1", 2'd2, 1'b1, 1'b0);
        clr(); reset = 1; cyc("rc_reset", 2'd2, 1'b1, 1'b0);
        clr(); cyc("rc_after", 2'd0, 1'b0, 1'b0);

        // Reset in cycle 4 of DIV_WAIT with x12 and x7 pending.
        clr(); issue_valid = 1; issue_load = 1; issue_rd = 5'd12;
        cyc("rd_ld_issue", 2'd0, 1'b0, 1'b0);
        clr(); dec_rs1 = 5'd12; dec_use_rs1 = 1;
        cyc("rd_ld_mem", 2'd1, 1'b1, 1'b1);
        clr(); issue_valid = 1; issue_div = 1; issue_rd = 5'd7;
        cyc("rd_div_issue", 2'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            clr(); reset = (i == 4); wb_we = (i == 4); wb_rd = 5'd3;
            cyc("rd_div_wait", 2'd3, 1'b1, 1'b0);
        end
        clr(); div_ready = 1;
        cyc("rd_late_ready", 2'd0, 1'b0, 1'b0);
        clr();
        cyc("rd_idle", 2'd0, 1'b0, 1'b0);
        for (int r = 1; r < 32; r++) begin
            clr(); dec_rs1 = 5'(r); dec_use_rs1 = 1; dec_rs2 = 5'(r); dec_use_rs2 = 1;
            cyc("rd_sb_zero", 2'd0, 1'b0, 1'b0);
        end

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port run, input, 1; when low, all state is held and issue inputs are ignored.
REQ-004 SHALL have port issue_valid, input, 1; the decoder accepted one instruction this cycle.
REQ-005 SHALL have ports issue_ctrl, issue_load, issue_div, input, 1 each; the accepted instruction is a branch/jal/jalr, a load, or a div/rem.
REQ-006 SHALL have port issue_rd, input, 5; destination register of the accepted instruction.
REQ-007 SHALL have ports dec_rs1, dec_rs2, input, 5 each, and dec_use_rs1, dec_use_rs2, input, 1 each; sources of the instruction currently at decode.
REQ-008 SHALL have port div_ready, input, 1; the divider result is valid this cycle.
REQ-009 SHALL have ports wb_we, input, 1, and wb_rd, input, 5; register-file write-back.
REQ-010 SHALL have port seq_stall, output, 1; structural/control stall from the sequencer.
REQ-011 SHALL have port raw_stall, output, 1; operand hazard from the scoreboard.
REQ-012 SHALL have port stall, output, 1, equal to seq_stall OR raw_stall.
REQ-013 SHALL have port hz_state, output, 2; current sequencer state encoding.

Function
REQ-014 SHALL treat an issue as accepted only when run & issue_valid & !stall.
REQ-015 SHALL implement states IDLE=0, MEM_WAIT=1, CTRL_WAIT=2, DIV_WAIT=3.
REQ-016 SHALL, on an accepted issue in IDLE, load counters: mem_cnt=1 if issue_load, ctrl_cnt=3 if issue_ctrl, div_pend=1 if issue_div; other counters are cleared.
REQ-017 SHALL service loaded counters in fixed order MEM_WAIT, then CTRL_WAIT, then DIV_WAIT, entering the first nonzero one on the next cycle; with none set it remains in IDLE.
REQ-018 SHALL, in MEM_WAIT or CTRL_WAIT, decrement the active counter each run cycle and leave the state when the counter reaches 0, entering the next nonzero category or IDLE.
REQ-019 SHALL, in DIV_WAIT, stay until div_ready=1, then clear div_pend and go to IDLE in the same cycle; div_ready outside DIV_WAIT is ignored.
REQ-020 SHALL drive seq_stall=1 combinationally whenever state != IDLE; seq_stall=0 in IDLE.
REQ-021 SHALL give total seq_stall cycles per issue: load 1, ctrl 3, load+ctrl 4, div = cycles until div_ready inclusive.
REQ-022 SHALL keep a 32-bit pending scoreboard; an accepted issue with (issue_load | issue_div) and issue_rd != 0 sets bit issue_rd.
REQ-023 SHALL clear bit wb_rd when wb_we=1; a same-cycle set and clear of the same bit leaves it set.
REQ-024 SHALL never set bit 0; rs==0 never causes raw_stall.
REQ-025 SHALL drive raw_stall=1 combinationally when (dec_use_rs1 & pending[dec_rs1]) | (dec_use_rs2 & pending[dec_rs2]).
REQ-026 SHALL update the scoreboard from write-back even while run=0 or while stalled.
REQ-027 SHALL keep hz_state equal to the registered state, with no added latency.

Reset
REQ-028 SHALL, on reset, set state=IDLE, all counters=0, scoreboard=0; hence stall=seq_stall=raw_stall=0 and hz_state=0 one cycle after reset is sampled.
REQ-029 SHALL give reset priority over every concurrent issue, write-back or div_ready, including reset asserted mid DIV_WAIT or mid CTRL_WAIT.

Structure
REQ-030 SHALL put the state enum (IDLE/MEM_WAIT/CTRL_WAIT/DIV_WAIT), CTRL_STALL_CYCLES=3 and MEM_STALL_CYCLES=1 in the shared core package next to the DIV_NOP op constants.
REQ-031 SHALL implement the scoreboard as one sub-module, hazard_scoreboard, and the sequencer inline.

Verification
REQ-032 SHALL check a bench case where an accepted load (issue_rd=5) is followed by dec_rs1=5, dec_use_rs1=1 -> seq_stall high 1 cycle, raw_stall high until wb_we with wb_rd=5, then both 0.
REQ-033 SHALL check a bench case where a jal is accepted -> hz_state goes 2 for exactly 3 cycles, then 0; seq_stall high those 3 cycles.
REQ-034 SHALL check a bench case where a div (rd=7) is accepted and div_ready arrives 10 cycles later -> seq_stall high 10 cycles, pending[7] set until write-back.
REQ-035 SHALL check a bench case where a load with issue_rd=0 is accepted and dec_rs1=0 -> raw_stall stays 0.
REQ-036 SHALL check a bench case where an accepted issue sets rd=9 in the same cycle as wb_we with wb_rd=9 -> pending[9]=1 afterwards.
REQ-037 SHALL check a bench case where reset is asserted in cycle 4 of DIV_WAIT -> next cycle hz_state=0, stall=0, scoreboard all zero; a late div_ready has no effect.
